mem_stage_unit: RTL

- Consumer end of the EX/MEM pipeline register.
- Reads the registered ALU result, store data, destination register and zero flag.
- Performs the data-memory access over a req/ready handshake to a multicycle data memory, stalling upstream stages while the access is pending.
- Resolves the branch decision and drives the MEM/WB register feeding writeback.

---
 rtl/mem_stage_unit_pkg.sv | 9 +
 rtl/mem_stage_unit_memwb_reg.sv | 42 ++++
 rtl/mem_stage_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_stage_unit_pkg.sv
// mem_stage_unit_pkg: shared state encoding, alignment mask and default timeout for the MEM stage.
package mem_stage_unit_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [31:0] WORD_MASK = 32'h0000_0003;
  localparam int DEF_TIMEOUT = 16;
  function automatic logic misaligned(input logic [31:0] addr);
    return |(addr & WORD_MASK);
  endfunction
endpackage

// File: rtl/mem_stage_unit_memwb_reg.sv
// memwb_reg: MEM/WB pipeline register with load, bubble and hold.
module memwb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic        ld_data,
  input  logic        valid,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic [31:0] alu,
  input  logic [4:0]  wreg,
  input  logic [31:0] rdata,
  output logic        valid_w,
  output logic        regwrite_w,
  output logic        memtoreg_w,
  output logic [31:0] rdata_w,
  output logic [31:0] alu_w,
  output logic [4:0]  wreg_w
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      rdata_w    <= '0;
      alu_w      <= '0;
      wreg_w     <= '0;
    end else if (load) begin
      valid_w    <= valid;
      regwrite_w <= regwrite & valid;
      memtoreg_w <= memtoreg;
      alu_w      <= alu;
      wreg_w     <= wreg;
      if (ld_data) rdata_w <= rdata;
    end else if (bubble) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM stage with req/ready data-memory handshake, timeout, branch resolve and MEM/WB drive.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validM,
  input  logic [31:0] aluout,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  writereg,
  input  logic        zero_flagM,
  input  logic        branchM,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic        regwriteM,
  input  logic        memtoregM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stallM,
  output logic        pcsrcM,
  output logic        bus_err,
  output logic        validW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic idle, mem_op, mis, timeout;
  assign idle    = state == IDLE;
  assign mem_op  = validM & (memreadM | memwriteM);
  assign mis     = misaligned(aluout);
  assign timeout = ~idle & ~dmem_ready & (cnt == CNT_W'(TIMEOUT));
  assign pcsrcM  = idle & validM & branchM & zero_flagM;
  // Releasing the stall on timeout lets EX/MEM advance, dropping the aborted instruction.
  assign stallM  = idle ? mem_op & ~mis : ~dmem_ready & ~timeout;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= (idle & mem_op & mis) | timeout;
      if (idle) begin
        if (mem_op & ~mis) begin
          state      <= BUSY;
          cnt        <= CNT_W'(1);
          dmem_req   <= 1'b1;
          dmem_we    <= memwriteM;
          dmem_addr  <= aluout;
          dmem_wdata <= WriteDataM;
        end
      end else if (dmem_ready | timeout) begin
        state    <= IDLE;
        dmem_req <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
  memwb_reg u_memwb (
    .clk        (clk),
    .reset      (reset),
    .load       (idle ? ~mem_op : dmem_ready),
    .bubble     (idle ? mem_op : timeout),
    .ld_data    (~idle & memreadM),
    .valid      (validM),
    .regwrite   (regwriteM),
    .memtoreg   (memtoregM),
    .alu        (aluout),
    .wreg       (writereg),
    .rdata      (dmem_rdata),
    .valid_w    (validW),
    .regwrite_w (RegWriteW),
    .memtoreg_w (MemtoRegW),
    .rdata_w    (ReadDataW),
    .alu_w      (ALUOutW),
    .wreg_w     (WriteRegW)
  );
endmodule
